// File: rtl/pattern_pkg.sv
// Shared definitions for the serial pattern detector and its serializer feed stage.
package pattern_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StGap   = 2'd2
   } state_e;

   localparam int unsigned GapCntW = 4;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out register; load wins over shift, vacated bits fill with zero.
module piso_shift_reg #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] data_in,
   output logic             ser_bit
);

   logic [WIDTH-1:0] shreg_q, shreg_d;

   always_comb begin
      shreg_d = shreg_q;
      if (load) begin
         shreg_d = data_in;
      end else if (shift_en) begin
         shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign ser_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/pattern_serializer.sv
// Valid/ready word loader that shifts each word out one bit per clock, with an optional
// idle gap after each word.
module pattern_serializer
   import pattern_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned GAP       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             done
);

   localparam int unsigned          CntW    = $clog2(WIDTH);
   localparam logic [CntW-1:0]      LastCnt = CntW'(WIDTH - 1);
   localparam logic [GapCntW-1:0]   LastGap = GapCntW'((GAP == 0) ? 0 : GAP - 1);

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [GapCntW-1:0]  gap_q, gap_d;
   logic                load, shift_en, ser_bit, last_bit, xfer;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      load     = 1'b0;
      shift_en = 1'b0;
      last_bit = (state_q == StShift) && (cnt_q == LastCnt);
      // Accepting in the last-bit cycle keeps ser_valid continuous across words.
      load_ready = (state_q == StIdle) || (last_bit && (GAP == 0));
      xfer       = load_valid && load_ready;

      unique case (state_q)
         StIdle: begin
            if (xfer) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            shift_en = 1'b1;
            if (!last_bit) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = '0;
               if (xfer) begin
                  load = 1'b1;
               end else if (GAP != 0) begin
                  gap_d   = '0;
                  state_d = StGap;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StGap: begin
            if (gap_q == LastGap) begin
               gap_d   = '0;
               state_d = StIdle;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
      end
   end

   piso_shift_reg #(
      .WIDTH    (WIDTH),
      .MSB_FIRST(MSB_FIRST)
   ) u_piso (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .shift_en(shift_en),
      .data_in (load_data),
      .ser_bit (ser_bit)
   );

   // All outputs decode flops only, so nothing depends combinationally on load_valid.
   assign ser_valid = (state_q == StShift);
   assign ser_out   = ser_bit & ser_valid;
   assign done      = last_bit;

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench: three serializer instances (defaults, GAP=2, LSB-first).
module tb_pattern_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic       lv [3];
   logic [7:0] ld [3];
   logic       lr [3];
   logic       so [3];
   logic       sv [3];
   logic       dn [3];

   int n_checks = 0;
   int n_fail   = 0;
   bit exp_q[$];

   always #5 clk = ~clk;

   pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) u_dut_def (
      .clk(clk), .reset(reset), .load_valid(lv[0]), .load_data(ld[0]), .load_ready(lr[0]),
      .ser_out(so[0]), .ser_valid(sv[0]), .done(dn[0])
   );
   pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2)) u_dut_gap (
      .clk(clk), .reset(reset), .load_valid(lv[1]), .load_data(ld[1]), .load_ready(lr[1]),
      .ser_out(so[1]), .ser_valid(sv[1]), .done(dn[1])
   );
   pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0)) u_dut_lsb (
      .clk(clk), .reset(reset), .load_valid(lv[2]), .load_data(ld[2]), .load_ready(lr[2]),
      .ser_out(so[2]), .ser_valid(sv[2]), .done(dn[2])
   );

   function automatic void push_word(input logic [7:0] w, input bit msb);
      for (int i = 0; i < 8; i++) exp_q.push_back(msb ? w[7-i] : w[i]);
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      for (int d = 0; d < 3; d++) begin
         lv[d] = 1'b0;
         ld[d] = 8'h00;
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         n_checks++;
         if ({so[d], sv[d], dn[d], lr[d]} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset dut%0d: {out,valid,done,ready}=%b required 0001", d,
                     {so[d], sv[d], dn[d], lr[d]});
         end
      end
   endtask

   task automatic test_single();
      bit b;
      @(negedge clk);
      lv[0] = 1'b1;
      ld[0] = 8'hB6;
      push_word(8'hB6, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         n_checks++;
         if ({sv[0], dn[0], lr[0]} !== {k <= 8, k == 8, k >= 8}) begin
            n_fail++;
            $display("FAIL single k=%0d: {valid,done,ready}=%b required %b", k,
                     {sv[0], dn[0], lr[0]}, {k <= 8, k == 8, k >= 8});
         end
         n_checks++;
         if (sv[0] && exp_q.size() > 0) begin
            b = exp_q.pop_front();
            if (so[0] !== b) begin
               n_fail++;
               $display("FAIL single bit k=%0d: ser_out=%b required %b", k, so[0], b);
            end
         end else if (so[0] !== 1'b0 || sv[0]) begin
            n_fail++;
            $display("FAIL single idle k=%0d: out=%b valid=%b required 0 0", k, so[0], sv[0]);
         end
         lv[0] = 1'b0;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL single drain: %0d bits left required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      bit b;
      @(negedge clk);
      lv[0] = 1'b1;
      ld[0] = 8'hA5;
      push_word(8'hA5, 1'b1);
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         n_checks++;
         if ({sv[0], dn[0], lr[0]} !== {k <= 16, k == 8 || k == 16, k == 8 || k >= 16}) begin
            n_fail++;
            $display("FAIL b2b k=%0d: {valid,done,ready}=%b required %b", k, {sv[0], dn[0], lr[0]},
                     {k <= 16, k == 8 || k == 16, k == 8 || k >= 16});
         end
         n_checks++;
         if (sv[0] && exp_q.size() > 0) begin
            b = exp_q.pop_front();
            if (so[0] !== b) begin
               n_fail++;
               $display("FAIL b2b bit k=%0d: ser_out=%b required %b", k, so[0], b);
            end
         end else if (so[0] !== 1'b0 || sv[0]) begin
            n_fail++;
            $display("FAIL b2b idle k=%0d: out=%b valid=%b required 0 0", k, so[0], sv[0]);
         end
         if (k == 1) begin
            ld[0] = 8'h3C;
            push_word(8'h3C, 1'b1);
         end
         if (k >= 9) lv[0] = 1'b0;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b drain: %0d bits left required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_gap();
      bit b, e_sv;
      @(negedge clk);
      lv[1] = 1'b1;
      ld[1] = 8'hFF;
      push_word(8'hFF, 1'b1);
      for (int k = 1; k <= 22; k++) begin
         @(negedge clk);
         e_sv = (k <= 8) || (k >= 12 && k <= 19);
         n_checks++;
         if ({sv[1], dn[1], lr[1]} !== {e_sv, k == 8 || k == 19, k == 11 || k == 22}) begin
            n_fail++;
            $display("FAIL gap k=%0d: {valid,done,ready}=%b required %b", k, {sv[1], dn[1], lr[1]},
                     {e_sv, k == 8 || k == 19, k == 11 || k == 22});
         end
         n_checks++;
         if (sv[1] && exp_q.size() > 0) begin
            b = exp_q.pop_front();
            if (so[1] !== b) begin
               n_fail++;
               $display("FAIL gap bit k=%0d: ser_out=%b required %b", k, so[1], b);
            end
         end else if (so[1] !== 1'b0 || sv[1]) begin
            n_fail++;
            $display("FAIL gap idle k=%0d: out=%b valid=%b required 0 0", k, so[1], sv[1]);
         end
         lv[1] = (k == 11);
         if (k == 11) begin
            ld[1] = 8'h01;
            push_word(8'h01, 1'b1);
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL gap drain: %0d bits left required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_lsb_first();
      bit b;
      @(negedge clk);
      lv[2] = 1'b1;
      ld[2] = 8'b0000_0011;
      push_word(8'b0000_0011, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         n_checks++;
         if ({sv[2], dn[2], lr[2]} !== {k <= 8, k == 8, k >= 8}) begin
            n_fail++;
            $display("FAIL lsb k=%0d: {valid,done,ready}=%b required %b", k,
                     {sv[2], dn[2], lr[2]}, {k <= 8, k == 8, k >= 8});
         end
         n_checks++;
         if (sv[2] && exp_q.size() > 0) begin
            b = exp_q.pop_front();
            if (so[2] !== b) begin
               n_fail++;
               $display("FAIL lsb bit k=%0d: ser_out=%b required %b", k, so[2], b);
            end
         end else if (so[2] !== 1'b0 || sv[2]) begin
            n_fail++;
            $display("FAIL lsb idle k=%0d: out=%b valid=%b required 0 0", k, so[2], sv[2]);
         end
         lv[2] = 1'b0;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL lsb drain: %0d bits left required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_busy_reject();
      bit b;
      @(negedge clk);
      lv[0] = 1'b1;
      ld[0] = 8'hF0;
      push_word(8'hF0, 1'b1);
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         n_checks++;
         if ({sv[0], dn[0], lr[0]} !== {k <= 8, k == 8, k >= 8}) begin
            n_fail++;
            $display("FAIL busy k=%0d: {valid,done,ready}=%b required %b", k,
                     {sv[0], dn[0], lr[0]}, {k <= 8, k == 8, k >= 8});
         end
         n_checks++;
         if (sv[0] && exp_q.size() > 0) begin
            b = exp_q.pop_front();
            if (so[0] !== b) begin
               n_fail++;
               $display("FAIL busy bit k=%0d: ser_out=%b required %b", k, so[0], b);
            end
         end else if (so[0] !== 1'b0 || sv[0]) begin
            n_fail++;
            $display("FAIL busy idle k=%0d: out=%b valid=%b required 0 0", k, so[0], sv[0]);
         end
         lv[0] = (k == 3);
         ld[0] = 8'h00;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL busy drain: %0d bits left required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid_word();
      bit b;
      @(negedge clk);
      lv[0] = 1'b1;
      ld[0] = 8'hC3;
      push_word(8'hC3, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         lv[0] = 1'b0;
         n_checks++;
         b = exp_q.pop_front();
         if ({sv[0], dn[0], lr[0], so[0]} !== {3'b100, b}) begin
            n_fail++;
            $display("FAIL rstmid k=%0d: {valid,done,ready,out}=%b required %b", k,
                     {sv[0], dn[0], lr[0], so[0]}, {3'b100, b});
         end
      end
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      for (int k = 5; k <= 12; k++) begin
         n_checks++;
         if ({so[0], sv[0], dn[0], lr[0]} !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstmid after k=%0d: {out,valid,done,ready}=%b required 0001", k,
                     {so[0], sv[0], dn[0], lr[0]});
         end
         @(negedge clk);
      end
      lv[0] = 1'b1;
      ld[0] = 8'h81;
      push_word(8'h81, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         n_checks++;
         if ({sv[0], dn[0], lr[0]} !== {k <= 8, k == 8, k >= 8}) begin
            n_fail++;
            $display("FAIL rstmid reload k=%0d: {valid,done,ready}=%b required %b", k,
                     {sv[0], dn[0], lr[0]}, {k <= 8, k == 8, k >= 8});
         end
         n_checks++;
         if (sv[0] && exp_q.size() > 0) begin
            b = exp_q.pop_front();
            if (so[0] !== b) begin
               n_fail++;
               $display("FAIL rstmid reload bit k=%0d: ser_out=%b required %b", k, so[0], b);
            end
         end else if (so[0] !== 1'b0 || sv[0]) begin
            n_fail++;
            $display("FAIL rstmid reload idle k=%0d: out=%b valid=%b required 0 0", k, so[0],
                     sv[0]);
         end
         lv[0] = 1'b0;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rstmid drain: %0d bits left required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_gap();
      test_lsb_first();
      test_busy_reject();
      test_reset_mid_word();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
- Upstream feed stage for the serial Mealy pattern detector.
- Accepts WIDTH-bit parallel words over a valid/ready handshake and shifts them out one bit per clock.
- `ser_out` drives the detector's serial `in`; `ser_valid` qualifies each bit.
- Optional idle gap between words; the gap lets the bench insert spacing between patterns.

Parameters:
- WIDTH, 8, word length in bits (minimum 2).
- MSB_FIRST, 1, 1 = shift MSB first; 0 = shift LSB first.
- GAP, 0, idle cycles inserted after each word's last bit (0..15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- load_valid  input  1  producer has a word on load_data
- load_data  input  WIDTH  parallel word to serialize
- load_ready  output  1  block can accept a word this cycle
- ser_out  output  1  serial bit to the pattern detector
- ser_valid  output  1  ser_out carries a live bit
- done  output  1  one-cycle pulse coincident with the last bit of a word

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled only on the clk rising edge.
- Reset values: state=IDLE, shift register=0, bit counter=0, gap counter=0, ser_out=0, ser_valid=0, done=0. load_ready=1 from the first cycle after reset.
- Transfer occurs at a rising edge where load_valid && load_ready. load_data is sampled only then; at all other times it is don't-care.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - load_ready=1, ser_valid=0, ser_out=0.
  - On transfer, go to SHIFT. The first bit appears on ser_out in the next cycle (latency 1).
- SHIFT:
  - Presents bits index WIDTH-1 down to 0 (MSB_FIRST=1) or 0 up to WIDTH-1 (MSB_FIRST=0), one per cycle.
  - ser_valid=1 for exactly WIDTH consecutive cycles.
  - Bit counter counts 0..WIDTH-1. Last-bit cycle is count==WIDTH-1; done=1 only in that cycle.
- load_ready in SHIFT:
  - 0, except in the last-bit cycle when GAP==0 (combinational on state/count).
  - A transfer in that cycle reloads the shifter and restarts at count 0. This gives seamless back-to-back words with no ser_valid bubble.
- After the last bit:
  - GAP==0: go to IDLE, or remain in SHIFT if a transfer occurred.
  - GAP>0: go to GAP.
- GAP state:
  - ser_valid=0, ser_out=0, load_ready=0 for exactly GAP cycles, then go to IDLE.
- load_valid asserted while load_ready=0: no transfer, no state effect. The producer must hold the word (standard valid/ready).
- Reset mid-word or mid-gap: the word is abandoned. All outputs take reset values on the next cycle and no done pulse is issued.
- ser_out and ser_valid are registered. done is registered and aligned to the last bit.
- No combinational path from load_valid to any output.

Decomposition:
- Shared package (pattern_pkg): state encoding constants (IDLE, SHIFT, GAP) and the GAP counter width constant (4 bits). The detector and its benches use the same package.
- One sub-module: piso_shift_reg, a WIDTH-bit parallel-in/serial-out register with load, shift_en and a MSB_FIRST parameter.
- Control FSM and counters stay in pattern_serializer.

Test Plan:
- Single word, defaults: release reset, load 8'b1011_0110 with a one-cycle valid.
  - Required: ser_out=1,0,1,1,0,1,1,0 on cycles 1..8 after transfer, ser_valid high exactly those 8 cycles, done high on cycle 8 only, load_ready low cycles 1..7.
- Back-to-back, GAP=0: hold load_valid with 8'hA5 then 8'h3C.
  - Required: 16 continuous ser_valid cycles, bits 10100101 00111100, done on cycles 8 and 16, second transfer on cycle 8.
- Gap insertion, GAP=2: two words 8'hFF, 8'h01.
  - Required: 8 valid bits, 2 cycles ser_valid=0 with load_ready=0, load_ready=1 on the following cycle, second word starts one cycle after its transfer.
- LSB first, MSB_FIRST=0: load 8'b0000_0011.
  - Required: ser_out=1,1,0,0,0,0,0,0, done on bit 8.
- Busy rejection: pulse load_valid with 8'h00 during bit 3 of a word 8'hF0.
  - Required: no transfer, output stream 11110000 unchanged, returns to IDLE afterwards.
- Reset mid-word: assert reset for one cycle during bit 4 of 8'hC3.
  - Required: next cycle ser_valid=0, ser_out=0, done=0, load_ready=1. No done pulse for the abandoned word. A following load of 8'h81 serializes correctly.
